// File: rtl/corelet_pkg.sv
// Shared corelet definitions: default array geometry and the
// accumulation-stage state encoding.
package corelet_pkg;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int IN_W    = 6;
    localparam int K       = 3;
    localparam int OUT_W   = IN_W - K + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/psum_addr_map.sv
// Maps an activation coordinate (nx, ny) under kernel offset (ki, kj)
// onto the output window. keep says whether the row lands inside it;
// addr is the row-major output pixel index.
module psum_addr_map
    import corelet_pkg::*;
#(
    parameter int out_w = OUT_W
) (
    input  logic [2:0] nx,
    input  logic [2:0] ny,
    input  logic [1:0] ki,
    input  logic [1:0] kj,
    output logic       keep,
    output logic [3:0] addr
);

    localparam logic signed [3:0] OUT_W_S = 4'(out_w);

    logic signed [3:0] ox;
    logic signed [3:0] oy;

    // Shift the activation coordinate back by the kernel offset and window-test it
    always_comb begin
        ox   = $signed({1'b0, nx}) - $signed({2'b00, kj});
        oy   = $signed({1'b0, ny}) - $signed({2'b00, ki});
        keep = (ox >= 4'sd0) && (ox < OUT_W_S) && (oy >= 4'sd0) && (oy < OUT_W_S);
        // The output window is 4x4, so the two low bits of each offset
        // concatenate directly into oy*4+ox.
        addr = {oy[1:0], ox[1:0]};
    end

endmodule

// File: rtl/psum_accum.sv
// Output-side partial-sum accumulator. Consumes one row per handshake
// for the current kernel offset, drops rows outside the output window
// and accumulates the rest into PMEM (direct write on the first pass,
// read-modify-write with saturation, and optional ReLU on the last).
module psum_accum
    import corelet_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int in_w    = IN_W,
    parameter int k       = K,
    parameter int out_w   = OUT_W,
    parameter bit relu_en = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pass_start,
    input  logic [3:0]               pass_kij,
    input  logic                     in_valid,
    input  logic [col*psum_bw-1:0]   in_data,
    output logic                     in_ready,
    output logic                     pass_done,
    output logic                     busy,
    input  logic [col*psum_bw-1:0]   OP_q,
    output logic [col*psum_bw-1:0]   OP_d,
    output logic [8:0]               OP_addr,
    output logic                     OP_cen,
    output logic                     OP_wen
);

    localparam int              ROWS     = in_w * in_w;
    localparam logic [5:0]      ROWS_L   = 6'(ROWS);
    localparam logic [5:0]      LAST_ROW = 6'(ROWS - 1);
    localparam logic [2:0]      NX_LAST  = 3'(in_w - 1);
    localparam logic [3:0]      K_L      = 4'(k);
    localparam logic [3:0]      KIJ_MAX  = 4'(k * k - 1);

    state_t                 state_q;
    logic [3:0]             kij_q;
    logic [1:0]             ki_q;
    logic [1:0]             kj_q;
    logic [2:0]             nx_q;
    logic [2:0]             ny_q;
    logic [5:0]             row_cnt_q;
    logic [col*psum_bw-1:0] lat_data_q;
    logic [3:0]             lat_addr_q;

    logic                   keep;
    logic [3:0]             map_addr;
    logic                   accept;
    logic                   rmw;
    logic                   relu_on;
    logic [col*psum_bw-1:0] wb_data;

    psum_addr_map #(
        .out_w (out_w)
    ) u_addr_map (
        .nx   (nx_q),
        .ny   (ny_q),
        .ki   (ki_q),
        .kj   (kj_q),
        .keep (keep),
        .addr (map_addr)
    );

    assign accept   = (state_q == RUN) && in_valid;
    assign rmw      = keep && (kij_q != 4'd0);
    assign relu_on  = relu_en && (kij_q == KIJ_MAX);

    // Handshake and status follow the registered state only
    assign in_ready  = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign pass_done = (state_q == DONE);

    genvar gi;
    generate
        for (gi = 0; gi < col; gi++) begin : g_lane
            logic [psum_bw-1:0] mem_lane;
            logic [psum_bw-1:0] add_lane;
            logic [psum_bw:0]   sum;
            logic [psum_bw-1:0] res;

            assign mem_lane = OP_q[gi*psum_bw +: psum_bw];
            assign add_lane = lat_data_q[gi*psum_bw +: psum_bw];

            // Sign-extended add, clamp on overflow, then zero negatives on the ReLU pass
            always_comb begin
                sum = {mem_lane[psum_bw-1], mem_lane} + {add_lane[psum_bw-1], add_lane};
                if (sum[psum_bw] != sum[psum_bw-1]) begin
                    res = sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                       : {1'b0, {(psum_bw-1){1'b1}}};
                end else begin
                    res = sum[psum_bw-1:0];
                end
                if (relu_on && res[psum_bw-1]) begin
                    res = '0;
                end
            end

            assign wb_data[gi*psum_bw +: psum_bw] = res;
        end
    endgenerate

    // PMEM port: RUN accesses follow the live handshake, WB replays latched address
    always_comb begin
        OP_cen  = 1'b1;
        OP_wen  = 1'b1;
        OP_addr = '0;
        OP_d    = '0;
        if (accept && keep) begin
            OP_cen  = 1'b0;
            OP_addr = {5'd0, map_addr};
            if (kij_q == 4'd0) begin
                OP_wen = 1'b0;
                OP_d   = in_data;
            end
        end else if (state_q == WB) begin
            OP_cen  = 1'b0;
            OP_wen  = 1'b0;
            OP_addr = {5'd0, lat_addr_q};
            OP_d    = wb_data;
        end
    end

    // Pass sequencing: counters, latched operands and state transitions
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            kij_q      <= '0;
            ki_q       <= '0;
            kj_q       <= '0;
            nx_q       <= '0;
            ny_q       <= '0;
            row_cnt_q  <= '0;
            lat_data_q <= '0;
            lat_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pass_start && (pass_kij <= KIJ_MAX)) begin
                        kij_q     <= pass_kij;
                        ki_q      <= 2'(pass_kij / K_L);
                        kj_q      <= 2'(pass_kij % K_L);
                        nx_q      <= '0;
                        ny_q      <= '0;
                        row_cnt_q <= '0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        row_cnt_q <= row_cnt_q + 6'd1;
                        if (nx_q == NX_LAST) begin
                            nx_q <= '0;
                            ny_q <= ny_q + 3'd1;
                        end else begin
                            nx_q <= nx_q + 3'd1;
                        end
                        if (rmw) begin
                            lat_data_q <= in_data;
                            lat_addr_q <= map_addr;
                            state_q    <= WB;
                        end else if (row_cnt_q == LAST_ROW) begin
                            state_q <= DONE;
                        end
                    end
                end
                WB: begin
                    // row_cnt_q already counts the row being written back
                    state_q <= (row_cnt_q == ROWS_L) ? DONE : RUN;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: a behavioural PMEM, a pass-level
// reference model of the accumulated window, and a table of passes
// with hand-computed spot values, followed by hand-written sequences
// for an illegal kernel offset and a reset landing in write-back.
module tb_psum_accum;

    logic         clk = 1'b0;
    logic         reset;
    logic         pass_start;
    logic [3:0]   pass_kij;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_ready;
    logic         pass_done;
    logic         busy;
    logic [127:0] OP_q;
    logic [127:0] OP_d;
    logic [8:0]   OP_addr;
    logic         OP_cen;
    logic         OP_wen;

    int checks = 0;
    int errors = 0;

    psum_accum #(.relu_en(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .pass_start (pass_start),
        .pass_kij   (pass_kij),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .pass_done  (pass_done),
        .busy       (busy),
        .OP_q       (OP_q),
        .OP_d       (OP_d),
        .OP_addr    (OP_addr),
        .OP_cen     (OP_cen),
        .OP_wen     (OP_wen)
    );

    always #5 clk = ~clk;

    // Behavioural PMEM: synchronous write, one-cycle read latency
    logic [127:0] pmem [16];
    int wr_cnt  = 0;
    int bad_adr = 0;
    always @(posedge clk) begin
        if (!OP_cen) begin
            if (OP_addr > 9'd15) bad_adr <= bad_adr + 1;
            if (!OP_wen) begin
                pmem[OP_addr[3:0]] <= OP_d;
                wr_cnt <= wr_cnt + 1;
            end else begin
                OP_q <= pmem[OP_addr[3:0]];
            end
        end
    end

    // Reference model of the 16 output rows, lanes as plain integers
    int model [16][8];

    function automatic int lane_pat(input int pat, input int nij, input int l);
        int p3 [8];
        int p4 [8];
        int p5 [8];
        p3 = '{32000, -32000, 32000, -32000, 5, -5, 0, 100};
        p4 = '{1000, -1000, 767, -768, 4, -4, -1, -200};
        p5 = '{0, 0, 0, 0, 0, 4, 0, 0};
        case (pat)
            0:       return nij;
            1:       return 1;
            3:       return p3[l];
            4:       return p4[l];
            default: return p5[l];
        endcase
    endfunction

    function automatic logic [127:0] row_data(input int pat, input int nij);
        logic [127:0] w;
        int v;
        w = '0;
        for (int l = 0; l < 8; l++) begin
            v = lane_pat(pat, nij, l);
            w[l*16 +: 16] = 16'(v);
        end
        return w;
    endfunction

    function automatic int lane_of(input logic [127:0] w, input int l);
        logic signed [15:0] s;
        s = w[l*16 +: 16];
        return int'(s);
    endfunction

    task automatic model_pass(input int kij, input int pat);
        int ox, oy, a, v;
        for (int nij = 0; nij < 36; nij++) begin
            ox = (nij % 6) - (kij % 3);
            oy = (nij / 6) - (kij / 3);
            if (ox >= 0 && ox < 4 && oy >= 0 && oy < 4) begin
                a = oy * 4 + ox;
                for (int l = 0; l < 8; l++) begin
                    if (kij == 0) begin
                        v = lane_pat(pat, nij, l);
                    end else begin
                        v = model[a][l] + lane_pat(pat, nij, l);
                        if (v > 32767) v = 32767;
                        if (v < -32768) v = -32768;
                        if (kij == 8 && v < 0) v = 0;
                    end
                    model[a][l] = v;
                end
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        logic [127:0] exp;
        for (int a = 0; a < 16; a++) begin
            exp = '0;
            for (int l = 0; l < 8; l++) exp[l*16 +: 16] = 16'(model[a][l]);
            checks++;
            if (pmem[a] !== exp) begin
                errors++;
                $display("FAIL %s pmem[%0d]: got %h, expected %h", tag, a, pmem[a], exp);
            end
        end
    endtask

    // Runs one pass; drives rows by index so a stalled row is simply re-presented
    task automatic run_pass(input logic [3:0] kij, input int pat, input bit rnd, input bit inject,
                            output int busy_cyc, output int wb_cyc, output int done_cnt,
                            output int rows, output int writes);
        int  guard;
        int  wr0;
        bit  acc;
        guard = 0; rows = 0; busy_cyc = 0; wb_cyc = 0; done_cnt = 0;
        wr0 = wr_cnt;
        @(negedge clk);
        pass_start = 1'b1;
        pass_kij   = kij;
        @(negedge clk);
        pass_start = 1'b0;
        while ((rows < 36 || busy) && guard < 600) begin
            if (busy && !pass_done) busy_cyc++;
            if (busy && !pass_done && !in_ready) wb_cyc++;
            if (pass_done) done_cnt++;
            in_valid = (rows < 36) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
            in_data  = row_data(pat, rows);
            if (inject && guard == 5) begin
                pass_start = 1'b1;
                pass_kij   = 4'd0;
            end else begin
                pass_start = 1'b0;
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) rows++;
            guard++;
        end
        in_valid   = 1'b0;
        pass_start = 1'b0;
        writes     = wr_cnt - wr0;
        if (guard >= 600) begin
            checks++;
            errors++;
            $display("FAIL pass_timeout kij=%0d: rows=%0d busy=%0d, expected completion", kij, rows, busy);
        end
    endtask

    typedef struct {
        logic [3:0] kij;
        int         pat;
        bit         rnd;
        bit         inject;
        int         exp_busy;   // -1 when valid is randomised
        int         exp_wb;
        int         addr;
        int         lane_a;
        int         val_a;
        int         lane_b;
        int         val_b;
    } pass_vec_t;

    pass_vec_t vecs [5];

    initial begin
        int  bc, wbc, dc, rows, wr;
        bit  found;
        bit  acc;

        vecs[0] = '{4'd0, 0, 1'b0, 1'b0, 36,  0,  5, 0,      7, 7,      7};
        vecs[1] = '{4'd4, 1, 1'b0, 1'b0, 52, 16, 15, 0,     22, 6,     22};
        vecs[2] = '{4'd0, 3, 1'b0, 1'b0, 36,  0,  3, 0,  32000, 1, -32000};
        vecs[3] = '{4'd1, 4, 1'b1, 1'b1, -1, 16,  6, 0,  32767, 1, -32768};
        vecs[4] = '{4'd8, 5, 1'b0, 1'b0, 52, 16, 10, 5,      0, 4,      9};

        reset      = 1'b1;
        pass_start = 1'b0;
        pass_kij   = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pass_done", int'(pass_done), 0);
        check("rst_cen", int'(OP_cen), 1);
        check("rst_wen", int'(OP_wen), 1);
        check("rst_addr", int'(OP_addr), 0);
        check("rst_d_zero", int'(OP_d == '0), 1);
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_pass(vecs[v].kij, vecs[v].pat, vecs[v].rnd, vecs[v].inject, bc, wbc, dc, rows, wr);
            model_pass(int'(vecs[v].kij), vecs[v].pat);
            $display("pass %0d kij=%0d busy=%0d wb=%0d done=%0d rows=%0d writes=%0d",
                     v, vecs[v].kij, bc, wbc, dc, rows, wr);
            if (vecs[v].exp_busy >= 0) check($sformatf("p%0d_cycles", v), bc, vecs[v].exp_busy);
            check($sformatf("p%0d_wb_cycles", v), wbc, vecs[v].exp_wb);
            check($sformatf("p%0d_done_pulses", v), dc, 1);
            check($sformatf("p%0d_rows", v), rows, 36);
            check($sformatf("p%0d_writes", v), wr, 16);
            check($sformatf("p%0d_spot_a", v), lane_of(pmem[vecs[v].addr], vecs[v].lane_a), vecs[v].val_a);
            check($sformatf("p%0d_spot_b", v), lane_of(pmem[vecs[v].addr], vecs[v].lane_b), vecs[v].val_b);
            check_mem($sformatf("p%0d", v));
        end

        // Out-of-range kernel offset must not open a pass
        @(negedge clk);
        pass_start = 1'b1;
        pass_kij   = 4'd9;
        @(negedge clk);
        pass_start = 1'b0;
        @(negedge clk);
        $display("kij9 start: busy=%0d cen=%0d", busy, OP_cen);
        check("kij9_busy", int'(busy), 0);
        check("kij9_cen", int'(OP_cen), 1);

        // Reset landing in a write-back cycle aborts the pass cleanly
        pass_kij   = 4'd2;
        pass_start = 1'b1;
        @(negedge clk);
        pass_start = 1'b0;
        in_valid   = 1'b1;
        rows       = 0;
        found      = 1'b0;
        for (int g = 0; g < 40 && !found; g++) begin
            in_data = row_data(1, rows);
            if (busy && !in_ready && !pass_done) begin
                found = 1'b1;
            end else begin
                acc = in_valid && in_ready;
                @(negedge clk);
                if (acc) rows++;
            end
        end
        check("reach_wb", int'(found), 1);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        $display("reset in WB: cen=%0d busy=%0d in_ready=%0d", OP_cen, busy, in_ready);
        check("wb_rst_cen", int'(OP_cen), 1);
        check("wb_rst_busy", int'(busy), 0);
        check("wb_rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        reset = 1'b0;

        // A fresh first pass rewrites every address
        run_pass(4'd0, 0, 1'b0, 1'b0, bc, wbc, dc, rows, wr);
        model_pass(0, 0);
        $display("post-reset pass busy=%0d done=%0d rows=%0d writes=%0d", bc, dc, rows, wr);
        check("post_cycles", bc, 36);
        check("post_done_pulses", dc, 1);
        check("post_writes", wr, 16);
        check("post_addr15", lane_of(pmem[15], 2), 21);
        check_mem("post");
        check("addr_range", bad_adr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
